// File: rtl/icache_mem_burst_ctrl.sv
// icache_mem_burst_ctrl
// Turns a single-cycle burst request into back-to-back reads of a fixed-latency
// backing memory, then streams the returned words out as beats with a last flag.
// Optional build macro: ICACHE_MEM_STATS_EN adds saturating burst/beat counters.
module icache_mem_burst_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MAX_BURST    = 8,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_req,
    input  logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic [$clog2(MAX_BURST):0]   mem_burst_len,
    output logic                         mem_ready,
    output logic                         mem_valid,
    output logic [DATA_WIDTH-1:0]        mem_data,
    output logic                         mem_last,
    output logic                         rd_en,
    output logic [ADDR_WIDTH-1:0]        rd_addr,
    input  logic [DATA_WIDTH-1:0]        rd_data
`ifdef ICACHE_MEM_STATS_EN
    ,
    output logic [31:0]                  stat_bursts,
    output logic [31:0]                  stat_beats
`endif
);

    localparam int unsigned STRIDE = DATA_WIDTH / 8;
    localparam int unsigned LEN_W  = $clog2(MAX_BURST) + 1;
    localparam int unsigned CNT_W  = LEN_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t                  r_state;
    logic                    r_mem_ready;
    logic                    r_mem_valid;
    logic                    r_mem_last;
    logic [DATA_WIDTH-1:0]   r_mem_data;
    logic                    r_rd_en;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic [CNT_W-1:0]        r_beats;
    logic [CNT_W-1:0]        r_issued;
    logic [CNT_W-1:0]        r_returned;
    logic [READ_LATENCY-1:0] r_pipe;

    logic [CNT_W-1:0]        w_len_p1;
    logic [CNT_W-1:0]        w_req_beats;
    logic [ADDR_WIDTH-1:0]   w_base;
    logic                    w_ret;

    // Clamp the requested length, word-align the base, and find returning reads.
    always_comb begin
        w_len_p1    = CNT_W'(mem_burst_len) + CNT_W'(1);
        w_req_beats = (w_len_p1 > CNT_W'(MAX_BURST)) ? CNT_W'(MAX_BURST) : w_len_p1;
        w_base      = mem_addr & ~ADDR_WIDTH'(STRIDE - 1);
        w_ret       = r_pipe[READ_LATENCY-1];
    end

    // Burst FSM: issue reads, track them through the latency pipe, emit beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mem_ready <= 1'b1;
            r_mem_valid <= 1'b0;
            r_mem_last  <= 1'b0;
            r_mem_data  <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_beats     <= '0;
            r_issued    <= '0;
            r_returned  <= '0;
            r_pipe      <= '0;
        end else begin
            // A bit enters the pipe with each rd_en; the MSB marks rd_data as ours.
            r_pipe      <= (r_pipe << 1) | READ_LATENCY'(r_rd_en);
            r_mem_valid <= w_ret;
            if (w_ret) begin
                r_mem_data <= rd_data;
                r_mem_last <= (r_returned == (r_beats - CNT_W'(1)));
                r_returned <= r_returned + CNT_W'(1);
            end else begin
                r_mem_last <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (mem_req) begin
                        r_state     <= S_ISSUE;
                        r_mem_ready <= 1'b0;
                        r_beats     <= w_req_beats;
                        r_rd_en     <= 1'b1;
                        r_rd_addr   <= w_base;
                        r_issued    <= CNT_W'(1);
                        r_returned  <= '0;
                    end
                end
                S_ISSUE: begin
                    if (r_issued < r_beats) begin
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= r_rd_addr + ADDR_WIDTH'(STRIDE);
                        r_issued  <= r_issued + CNT_W'(1);
                    end else begin
                        r_rd_en   <= 1'b0;
                        r_rd_addr <= '0;
                        r_state   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_mem_last) begin
                        r_state     <= S_IDLE;
                        r_mem_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_mem_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef ICACHE_MEM_STATS_EN
    logic [31:0] r_stat_bursts;
    logic [31:0] r_stat_beats;

    // Saturating counters of delivered beats and completed bursts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_bursts <= '0;
            r_stat_beats  <= '0;
        end else begin
            if (r_mem_valid && (r_stat_beats != '1)) begin
                r_stat_beats <= r_stat_beats + 32'd1;
            end
            if (r_mem_valid && r_mem_last && (r_stat_bursts != '1)) begin
                r_stat_bursts <= r_stat_bursts + 32'd1;
            end
        end
    end

    assign stat_bursts = r_stat_bursts;
    assign stat_beats  = r_stat_beats;
`endif

    assign mem_ready = r_mem_ready;
    assign mem_valid = r_mem_valid;
    assign mem_data  = r_mem_data;
    assign mem_last  = r_mem_last;
    assign rd_en     = r_rd_en;
    assign rd_addr   = r_rd_addr;

endmodule

// File: tb/tb_icache_mem_burst_ctrl.sv
// Directed bench for icache_mem_burst_ctrl: one instance at READ_LATENCY=1 and
// one at READ_LATENCY=3, selected by sel; backing memory returns addr ^ XK.
module tb_icache_mem_burst_ctrl;

    localparam logic [31:0] XK = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_len;
    int          sel;
    int          n_checks = 0;
    int          n_fail   = 0;

    logic        req1, rdy1, val1, last1, rden1;
    logic [31:0] data1, rdaddr1, rddata1;
    logic        req3, rdy3, val3, last3, rden3;
    logic [31:0] data3, rdaddr3, rddata3;

    assign req1 = mem_req & (sel == 0);
    assign req3 = mem_req & (sel != 0);

`ifdef ICACHE_MEM_STATS_EN
    logic [31:0] sb1, sbt1, sb3, sbt3;
`endif

    icache_mem_burst_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(8), .READ_LATENCY(1)) u_dut (
        .clk(clk), .rst(rst), .mem_req(req1), .mem_addr(mem_addr), .mem_burst_len(mem_len),
        .mem_ready(rdy1), .mem_valid(val1), .mem_data(data1), .mem_last(last1),
        .rd_en(rden1), .rd_addr(rdaddr1), .rd_data(rddata1)
`ifdef ICACHE_MEM_STATS_EN
        , .stat_bursts(sb1), .stat_beats(sbt1)
`endif
    );

    icache_mem_burst_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(8), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .mem_req(req3), .mem_addr(mem_addr), .mem_burst_len(mem_len),
        .mem_ready(rdy3), .mem_valid(val3), .mem_data(data3), .mem_last(last3),
        .rd_en(rden3), .rd_addr(rdaddr3), .rd_data(rddata3)
`ifdef ICACHE_MEM_STATS_EN
        , .stat_bursts(sb3), .stat_beats(sbt3)
`endif
    );

    // Backing memory model: fixed-latency address pipeline, data = addr ^ XK.
    logic [31:0] ap1 = '0;
    logic [31:0] ap3_0 = '0, ap3_1 = '0, ap3_2 = '0;
    always @(posedge clk) begin
        ap1   <= rdaddr1;
        ap3_0 <= rdaddr3;
        ap3_1 <= ap3_0;
        ap3_2 <= ap3_1;
    end
    assign rddata1 = ap1 ^ XK;
    assign rddata3 = ap3_2 ^ XK;

    // Outputs of the selected instance.
    logic        s_rdy, s_val, s_last, s_rden;
    logic [31:0] s_data, s_rdaddr;
    assign s_rdy    = (sel != 0) ? rdy3    : rdy1;
    assign s_val    = (sel != 0) ? val3    : val1;
    assign s_last   = (sel != 0) ? last3   : last1;
    assign s_rden   = (sel != 0) ? rden3   : rden1;
    assign s_data   = (sel != 0) ? data3   : data1;
    assign s_rdaddr = (sel != 0) ? rdaddr3 : rdaddr1;

    // Accept at cycle T, then check every output each cycle through T+2+L+beats.
    task automatic run_burst(input logic [31:0] addr, input logic [3:0] len,
                             input int beats, input int extra_n);
        int          lat;
        logic [31:0] base, ea, last_d;
        logic        exp_en, exp_v, exp_l, exp_r;
        lat    = (sel != 0) ? 3 : 1;
        base   = addr & 32'hFFFF_FFFC;
        last_d = s_data;
        @(negedge clk);
        n_checks++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL accept_ready addr=%h got=%b exp=1", addr, s_rdy); end
        mem_addr = addr; mem_len = len; mem_req = 1'b1;
        for (int n = 1; n <= 2 + lat + beats; n++) begin
            @(negedge clk);
            mem_req  = (n == extra_n);
            mem_addr = 32'h5555_0000;
            mem_len  = 4'hF;
            exp_en = (n <= beats);
            ea     = exp_en ? base + 32'(n - 1) * 32'd4 : 32'h0;
            exp_v  = (n >= 2 + lat) && (n <= 1 + lat + beats);
            exp_l  = (n == 1 + lat + beats);
            exp_r  = (n == 2 + lat + beats);
            if (exp_v) last_d = (base + 32'(n - 2 - lat) * 32'd4) ^ XK;
            n_checks++; if (s_rden !== exp_en) begin n_fail++; $display("FAIL rd_en addr=%h n=%0d got=%b exp=%b", addr, n, s_rden, exp_en); end
            n_checks++; if (s_rdaddr !== ea) begin n_fail++; $display("FAIL rd_addr addr=%h n=%0d got=%h exp=%h", addr, n, s_rdaddr, ea); end
            n_checks++; if (s_val !== exp_v) begin n_fail++; $display("FAIL mem_valid addr=%h n=%0d got=%b exp=%b", addr, n, s_val, exp_v); end
            n_checks++; if (s_last !== exp_l) begin n_fail++; $display("FAIL mem_last addr=%h n=%0d got=%b exp=%b", addr, n, s_last, exp_l); end
            n_checks++; if (s_rdy !== exp_r) begin n_fail++; $display("FAIL mem_ready addr=%h n=%0d got=%b exp=%b", addr, n, s_rdy, exp_r); end
            if (exp_v || exp_r) begin
                n_checks++; if (s_data !== last_d) begin n_fail++; $display("FAIL mem_data addr=%h n=%0d got=%h exp=%h", addr, n, s_data, last_d); end
            end
        end
        mem_req = 1'b0;
    endtask

    task automatic test_reset();
        sel = 0; rst = 1'b1; mem_req = 1'b1; mem_addr = 32'h1000; mem_len = 4'd7;
        repeat (2) @(negedge clk);
        n_checks++; if (s_rdy !== 1'b1)   begin n_fail++; $display("FAIL rst_ready got=%b exp=1", s_rdy); end
        n_checks++; if (s_val !== 1'b0)   begin n_fail++; $display("FAIL rst_valid got=%b exp=0", s_val); end
        n_checks++; if (s_last !== 1'b0)  begin n_fail++; $display("FAIL rst_last got=%b exp=0", s_last); end
        n_checks++; if (s_rden !== 1'b0)  begin n_fail++; $display("FAIL rst_rd_en got=%b exp=0", s_rden); end
        n_checks++; if (s_rdaddr !== '0)  begin n_fail++; $display("FAIL rst_rd_addr got=%h exp=0", s_rdaddr); end
        n_checks++; if (s_data !== '0)    begin n_fail++; $display("FAIL rst_mem_data got=%h exp=0", s_data); end
        rst = 1'b0; mem_req = 1'b0;
        @(negedge clk);
        n_checks++; if (s_rdy !== 1'b1)   begin n_fail++; $display("FAIL rst_req_ignored_ready got=%b exp=1", s_rdy); end
        n_checks++; if (s_rden !== 1'b0)  begin n_fail++; $display("FAIL rst_req_ignored_rd_en got=%b exp=0", s_rden); end
    endtask

    task automatic test_burst_len7();     sel = 0; run_burst(32'h0000_1040, 4'd7, 8, 0); endtask
    task automatic test_single_beat();    sel = 0; run_burst(32'h0000_1043, 4'd0, 1, 0); endtask
    task automatic test_addr_wrap();      sel = 0; run_burst(32'hFFFF_FFF8, 4'd3, 4, 0); endtask
    task automatic test_clamp_extra_req(); sel = 0; run_burst(32'h0000_2000, 4'd15, 8, 3); endtask

    task automatic test_back_to_back();
        sel = 0;
        run_burst(32'h0000_0100, 4'd1, 2, 0);
        run_burst(32'h0000_0204, 4'd2, 3, 0);
    endtask

`ifdef ICACHE_MEM_STATS_EN
    task automatic test_stats();
        sel = 0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (sb1 !== 32'd0)  begin n_fail++; $display("FAIL stat_bursts_rst got=%0d exp=0", sb1); end
        n_checks++; if (sbt1 !== 32'd0) begin n_fail++; $display("FAIL stat_beats_rst got=%0d exp=0", sbt1); end
        run_burst(32'h0000_1040, 4'd7, 8, 0);
        run_burst(32'h0000_1043, 4'd0, 1, 0);
        n_checks++; if (sb1 !== 32'd2)  begin n_fail++; $display("FAIL stat_bursts got=%0d exp=2", sb1); end
        n_checks++; if (sbt1 !== 32'd9) begin n_fail++; $display("FAIL stat_beats got=%0d exp=9", sbt1); end
    endtask
`endif

    task automatic test_rst_midburst();
        sel = 1;
        @(negedge clk);
        mem_addr = 32'h0000_3000; mem_len = 4'd7; mem_req = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            mem_req = 1'b0;
        end
        n_checks++; if (s_val !== 1'b1) begin n_fail++; $display("FAIL mid_beat3_valid got=%b exp=1", s_val); end
        n_checks++; if (s_data !== (32'h0000_300C ^ XK)) begin n_fail++; $display("FAIL mid_beat3_data got=%h exp=%h", s_data, 32'h0000_300C ^ XK); end
        rst = 1'b1; mem_req = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_req = 1'b0;
        n_checks++; if (s_rdy !== 1'b1)  begin n_fail++; $display("FAIL mid_rst_ready got=%b exp=1", s_rdy); end
        n_checks++; if (s_val !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_valid got=%b exp=0", s_val); end
        n_checks++; if (s_last !== 1'b0) begin n_fail++; $display("FAIL mid_rst_last got=%b exp=0", s_last); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_checks++; if (s_val !== 1'b0)  begin n_fail++; $display("FAIL stale_valid k=%0d got=%b exp=0", k, s_val); end
            n_checks++; if (s_rden !== 1'b0) begin n_fail++; $display("FAIL stale_rd_en k=%0d got=%b exp=0", k, s_rden); end
        end
        run_burst(32'h0000_0200, 4'd3, 4, 0);
    endtask

    initial begin
        rst = 1'b1; mem_req = 1'b0; mem_addr = '0; mem_len = '0; sel = 0;
        test_reset();
        test_burst_len7();
        test_single_beat();
        test_addr_wrap();
        test_clamp_extra_req();
        test_back_to_back();
`ifdef ICACHE_MEM_STATS_EN
        test_stats();
`endif
        test_rst_midburst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
